// File: rtl/rf_2p_be_arb_pkg.sv
// Shared encodings for rf_2p_be_arb: clear-engine FSM states and round-robin pointer.
package rf_2p_be_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_e;

    // Pointer value names the requester that wins the next contention.
    typedef enum logic {
        RR_FAV0 = 1'b0,
        RR_FAV1 = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves to the loser only on contention.
module rr_arb2
    import rf_2p_be_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_ptr_e ptr_reg, ptr_next;

    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr_reg;
        if (en) begin
            if (req == 2'b11) begin
                if (ptr_reg == RR_FAV0) begin
                    gnt      = 2'b01;
                    ptr_next = RR_FAV1;
                end else begin
                    gnt      = 2'b10;
                    ptr_next = RR_FAV0;
                end
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= RR_FAV0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/rf_2p_be_arb.sv
// Arbiter/sequencer for a two-port byte-enable register file with a zero-fill clear engine.
// Define RF_BYPASS_EN to make same-cycle read/write hits return the newly written bytes.
module rf_2p_be_arb
    import rf_2p_be_arb_pkg::*;
#(
    parameter  int Word_Width = 32,
    parameter  int Addr_Width = 8,
    localparam int Byte_Width = Word_Width >> 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_start_i,
    output logic                  clr_busy_o,
    output logic                  clr_done_o,
    input  logic                  w0_req_i,
    input  logic [Addr_Width-1:0] w0_addr_i,
    input  logic [Word_Width-1:0] w0_data_i,
    input  logic [Byte_Width-1:0] w0_be_i,
    output logic                  w0_gnt_o,
    input  logic                  w1_req_i,
    input  logic [Addr_Width-1:0] w1_addr_i,
    input  logic [Word_Width-1:0] w1_data_i,
    input  logic [Byte_Width-1:0] w1_be_i,
    output logic                  w1_gnt_o,
    input  logic                  r0_req_i,
    input  logic [Addr_Width-1:0] r0_addr_i,
    output logic                  r0_gnt_o,
    output logic                  r0_vld_o,
    input  logic                  r1_req_i,
    input  logic [Addr_Width-1:0] r1_addr_i,
    output logic                  r1_gnt_o,
    output logic                  r1_vld_o,
    output logic [Word_Width-1:0] rd_data_o,
    output logic                  rf_cena_o,
    output logic [Addr_Width-1:0] rf_addra_o,
    input  logic [Word_Width-1:0] rf_dataa_i,
    output logic                  rf_cenb_o,
    output logic [Byte_Width-1:0] rf_wenb_o,
    output logic [Addr_Width-1:0] rf_addrb_o,
    output logic [Word_Width-1:0] rf_datab_o
);

    localparam logic [Addr_Width-1:0] CNT_LAST = {Addr_Width{1'b1}};

    clr_state_e            state_reg, state_next;
    logic [Addr_Width-1:0] cnt_reg, cnt_next;
    logic [1:0]            w_gnt, r_gnt, r_vld_reg;
    logic                  arb_en;
    logic [Addr_Width-1:0] w_addr;
    logic [Word_Width-1:0] w_data;
    logic [Byte_Width-1:0] w_be;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE:  if (clr_start_i) state_next = ST_CLEAR;
            ST_CLEAR: begin
                cnt_next = cnt_reg + Addr_Width'(1);
                if (cnt_reg == CNT_LAST) state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            r_vld_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            r_vld_reg <= r_gnt;
        end
    end

    assign clr_busy_o = (state_reg == ST_CLEAR);
    assign clr_done_o = (state_reg == ST_DONE);

    // The sweep owns port B and grants are also held off on port A so no read races the fill.
    assign arb_en = !rst && (state_reg != ST_CLEAR);

    rr_arb2 u_warb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({w1_req_i, w0_req_i}),
        .gnt (w_gnt)
    );

    rr_arb2 u_rarb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({r1_req_i, r0_req_i}),
        .gnt (r_gnt)
    );

    assign {w1_gnt_o, w0_gnt_o} = w_gnt;
    assign {r1_gnt_o, r0_gnt_o} = r_gnt;
    assign {r1_vld_o, r0_vld_o} = r_vld_reg;

    assign w_addr = w_gnt[1] ? w1_addr_i : w0_addr_i;
    assign w_data = w_gnt[1] ? w1_data_i : w0_data_i;
    assign w_be   = w_gnt[1] ? w1_be_i   : w0_be_i;

    always_comb begin
        rf_cenb_o  = 1'b1;
        rf_wenb_o  = '1;
        rf_addrb_o = '0;
        rf_datab_o = '0;
        if (state_reg == ST_CLEAR) begin
            rf_cenb_o  = 1'b0;
            rf_wenb_o  = '0;
            rf_addrb_o = cnt_reg;
        end else if ((|w_gnt) && (|w_be)) begin
            rf_cenb_o  = 1'b0;
            rf_wenb_o  = ~w_be;
            rf_addrb_o = w_addr;
            rf_datab_o = w_data;
        end
    end

    always_comb begin
        rf_cena_o  = 1'b1;
        rf_addra_o = '0;
        if (|r_gnt) begin
            rf_cena_o  = 1'b0;
            rf_addra_o = r_gnt[1] ? r1_addr_i : r0_addr_i;
        end
    end

`ifdef RF_BYPASS_EN
    logic                  byp_hit_reg;
    logic [Word_Width-1:0] byp_data_reg;
    logic [Byte_Width-1:0] byp_be_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_hit_reg  <= 1'b0;
            byp_data_reg <= '0;
            byp_be_reg   <= '0;
        end else begin
            byp_hit_reg  <= !rf_cena_o && !rf_cenb_o && (rf_addra_o == rf_addrb_o);
            byp_data_reg <= rf_datab_o;
            byp_be_reg   <= ~rf_wenb_o;
        end
    end

    for (genvar gi = 0; gi < Byte_Width; gi++) begin : g_byp
        assign rd_data_o[gi*8 +: 8] = (byp_hit_reg && byp_be_reg[gi]) ? byp_data_reg[gi*8 +: 8]
                                                                      : rf_dataa_i[gi*8 +: 8];
    end
`else
    assign rd_data_o = rf_dataa_i;
`endif

endmodule
